wb_regfile: RTL

Write-back end of the MEM/WB interface. It consumes the registered MEM/WB outputs, selects the write-back value, and commits it to a 32-entry integer register file. The two read ports serve the ID stage. Same-cycle write-to-read bypass is provided, and committed register writes are counted for performance monitoring.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/regfile_core.sv | 43 ++++
 rtl/wb_regfile.sv | 96 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file widths, x0 constant and types
//
// Purpose: common sizing for the write-back stage and its register array.
//   XLEN       : data width of architectural registers
//   NREGS      : number of architectural registers
//   REG_ADDR_W : register index width, clog2(NREGS)
//   REG_X0     : index of the hardwired-zero register
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = '0;

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - NREGS x XLEN flop array, one write port, two raw read ports
//
// Purpose: storage for the integer register file. Reads are raw array
// contents; x0 masking and bypass live in the parent.
// Ports:
//   clk            : rising-edge clock
//   reset          : synchronous active-low clear of every entry
//   i_we           : write enable (caller already excludes x0 and reset)
//   i_waddr        : write index
//   i_wdata        : write data
//   i_raddr1/2     : combinational read indices
//   o_rdata1/2     : raw array contents at the read indices
module regfile_core
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_we,
  input  reg_addr_t i_waddr,
  input  xlen_t     i_wdata,
  input  reg_addr_t i_raddr1,
  input  reg_addr_t i_raddr2,
  output xlen_t     o_rdata1,
  output xlen_t     o_rdata2
);

  xlen_t r_regs [NREGS];

  // Clear has priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back mux, register file commit, bypass and commit counter
//
// Purpose: selects the write-back value, commits it to the register file,
// serves two ID-stage read ports with write-first bypass, and counts
// committed writes to non-zero destinations.
// Ports:
//   clk, reset        : clock; synchronous active-low reset
//   wb_memtoreg       : 1 selects load data, 0 selects ALU result
//   wb_regwrite_en    : commit enable from MEM/WB
//   wb_read_data      : load data
//   wb_aluresult      : ALU result
//   wb_write_address  : destination register rd
//   rs1_addr/rs2_addr : ID-stage read indices
//   rs1_data/rs2_data : combinational read data
//   wb_data           : combinational write-back value for EX forwarding
//   wb_commit         : registered, high one cycle after a committed write
//   wb_write_count    : registered, wrapping count of committed writes
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_memtoreg,
  input  logic             wb_regwrite_en,
  input  xlen_t            wb_read_data,
  input  xlen_t            wb_aluresult,
  input  reg_addr_t        wb_write_address,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output xlen_t            rs1_data,
  output xlen_t            rs2_data,
  output xlen_t            wb_data,
  output logic             wb_commit,
  output logic [CNT_W-1:0] wb_write_count
);

  xlen_t            w_wb_data;
  logic             w_we;
  xlen_t            w_raw1;
  xlen_t            w_raw2;
  logic             r_commit;
  logic [CNT_W-1:0] r_write_count;

  assign w_wb_data = wb_memtoreg ? wb_read_data : wb_aluresult;
  assign wb_data   = w_wb_data;

  // Including reset in the enable also turns the bypass off during reset,
  // so reads then show the array contents being cleared.
  assign w_we = reset & wb_regwrite_en & (wb_write_address != REG_X0);

  regfile_core u_core (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_we),
    .i_waddr  (wb_write_address),
    .i_wdata  (w_wb_data),
    .i_raddr1 (rs1_addr),
    .i_raddr2 (rs2_addr),
    .o_rdata1 (w_raw1),
    .o_rdata2 (w_raw2)
  );

  always_comb begin
    rs1_data = w_raw1;
    if (rs1_addr == REG_X0) begin
      rs1_data = '0;
    end else if (w_we && (rs1_addr == wb_write_address)) begin
      rs1_data = w_wb_data;
    end
  end

  always_comb begin
    rs2_data = w_raw2;
    if (rs2_addr == REG_X0) begin
      rs2_data = '0;
    end else if (w_we && (rs2_addr == wb_write_address)) begin
      rs2_data = w_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_commit      <= 1'b0;
      r_write_count <= '0;
    end else begin
      r_commit      <= w_we;
      r_write_count <= r_write_count + {{(CNT_W-1){1'b0}}, w_we};
    end
  end

  assign wb_commit      = r_commit;
  assign wb_write_count = r_write_count;

endmodule
